// File: rtl/switch_debounce_sync_if.sv
// Switch conditioning bus: raw pins in, debounced word, change strobe/mask and edge flags out.
// Use the master modport on the system side and the slave modport on the conditioner.
interface switch_debounce_sync_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_db;
  logic             sw_valid;
  logic             sw_changed;
  logic [WIDTH-1:0] sw_change_mask;
  logic [WIDTH-1:0] edge_clear;
  logic [WIDTH-1:0] edge_capture;

  modport master (
    output sw_raw, edge_clear,
    input  sw_db, sw_valid, sw_changed, sw_change_mask, edge_capture
  );

  modport slave (
    input  sw_raw, edge_clear,
    output sw_db, sw_valid, sw_changed, sw_change_mask, edge_capture
  );
endinterface

// File: rtl/switch_debounce_sync.sv
// Slide-switch conditioner: per-bit 2-FF synchroniser plus debounce counter, with a change strobe and mask.
// Define SWITCH_EDGE_CAPTURE_EN to build the sticky per-bit edge_capture flags.
module switch_debounce_sync #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic                 clk_clk,
  input logic                 reset_reset_n,
  switch_debounce_sync_if.slave sw
);
  localparam int             CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {FILL, LOAD, RUN} state_t;

  state_t           state_reg;
  logic             fill_cnt_reg;
  logic             valid_reg;
  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] db_reg;
  logic [WIDTH-1:0] mask_reg;
  logic             changed_reg;
  logic [CNT_W-1:0] cnt_reg  [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] flip;
  logic             in_run;

  assign in_run = (state_reg == RUN);

  // Startup sequencer: give the synchroniser two clocks to fill, then seed sw_db once.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg    <= FILL;
      fill_cnt_reg <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if (fill_cnt_reg) state_reg <= LOAD;
          fill_cnt_reg <= 1'b1;
        end
        LOAD: begin
          state_reg <= RUN;
          valid_reg <= 1'b1;
        end
        RUN:     state_reg <= RUN;
        default: state_reg <= FILL;
      endcase
    end
  end

  // A bit flips on its DEBOUNCE_CYCLES-th consecutive mismatching sample; any match restarts the count.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic match;
    logic at_limit;
    assign match        = (sync2_reg[gi] == db_reg[gi]);
    assign at_limit     = (cnt_reg[gi] == LIMIT);
    assign flip[gi]     = in_run && !match && at_limit;
    assign cnt_next[gi] = (!in_run || match || at_limit) ? '0 : cnt_reg[gi] + CNT_W'(1);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      db_reg      <= '0;
      mask_reg    <= '0;
      changed_reg <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_reg[i] <= '0;
    end else begin
      sync1_reg   <= sw.sw_raw;
      sync2_reg   <= sync1_reg;
      db_reg      <= (state_reg == LOAD) ? sync2_reg : (db_reg ^ flip);
      mask_reg    <= flip;
      changed_reg <= |flip;
      cnt_reg     <= cnt_next;
    end
  end

  assign sw.sw_db          = db_reg;
  assign sw.sw_valid       = valid_reg;
  assign sw.sw_changed     = changed_reg;
  assign sw.sw_change_mask = mask_reg;

`ifdef SWITCH_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] edge_reg;

  // A flip in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) edge_reg <= '0;
    else                edge_reg <= (edge_reg & ~sw.edge_clear) | flip;
  end

  assign sw.edge_capture = edge_reg;
`else
  logic unused_edge_clear;
  assign unused_edge_clear = ^sw.edge_clear;
  assign sw.edge_capture   = '0;
`endif
endmodule
